exu_seq: RTL and testbench



---
 rtl/exu_pkg.sv | 43 ++++
 rtl/exu_alu_ctr_dec.sv | 44 ++++
 rtl/exu_seq.sv | 171 +++++++++++++++++
 tb/tb_exu_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared definitions for the execute sequencer: op classes, ALU control codes, FSM states.
package exu_pkg;

    localparam logic [2:0] OPC_OP     = 3'd0;
    localparam logic [2:0] OPC_OPIMM  = 3'd1;
    localparam logic [2:0] OPC_BRANCH = 3'd2;
    localparam logic [2:0] OPC_JAL    = 3'd3;
    localparam logic [2:0] OPC_JALR   = 3'd4;
    localparam logic [2:0] OPC_LUI    = 3'd5;
    localparam logic [2:0] OPC_AUIPC  = 3'd6;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_RESP = 2'd3
    } exu_state_e;

    // Branch outcome from the first-pass ALU flags.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic less);
        case (funct3)
            3'b000:         return zero;
            3'b001:         return !zero;
            3'b100, 3'b110: return less;
            3'b101, 3'b111: return !less;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_alu_ctr_dec.sv
// Combinational decode of (op class, funct3, bit 30) into the ALU control code and an illegal flag.
module exu_alu_ctr_dec
    import exu_pkg::*;
(
    input  logic [2:0] opc,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [3:0] alu_ctr,
    output logic       illegal
);

    always_comb begin
        alu_ctr = ALU_ADD;
        illegal = 1'b0;
        case (opc)
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'b000:  alu_ctr = (f7b5 && opc == OPC_OP) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctr = ALU_SLL;
                    3'b010:  alu_ctr = ALU_SLT;
                    3'b011:  alu_ctr = ALU_SLTU;
                    3'b100:  alu_ctr = ALU_XOR;
                    3'b101:  alu_ctr = f7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctr = ALU_OR;
                    default: alu_ctr = ALU_AND;
                endcase
                // Bit 30 is only meaningful for sub (register form) and sra.
                illegal = f7b5 && !(funct3 == 3'b101 || (funct3 == 3'b000 && opc == OPC_OP));
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctr = ALU_SUB;
                    3'b100, 3'b101: alu_ctr = ALU_SLT;
                    3'b110, 3'b111: alu_ctr = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_LUI:                       alu_ctr = ALU_LUI;
            OPC_JAL, OPC_JALR, OPC_AUIPC:  alu_ctr = ALU_ADD;
            default:                       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exu_seq.sv
// Multi-cycle execute sequencer driving an external ALU for one or two passes per instruction.
// Optional performance counters are built when EXU_PERF_CNT_EN is defined.
module exu_seq
    import exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_opc,
    input  logic [2:0]      in_funct3,
    input  logic            in_f7b5,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctr,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_less,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd_val,
    output logic            out_wen,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_taken,
    output logic            out_illegal,
    output logic [31:0]     perf_retired,
    output logic [31:0]     perf_taken
);

    exu_state_e      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, rs1_reg, rs2_reg, imm_reg;
    logic [2:0]      opc_reg, funct3_reg;
    logic            f7b5_reg;
    logic [XLEN-1:0] rd_val_reg, next_pc_reg;
    logic            wen_reg, taken_reg, illegal_reg, out_valid_reg;
    logic [3:0]      dec_ctr;
    logic            dec_illegal;
    logic            take_now;
    logic [XLEN-1:0] pc_plus4;

    exu_alu_ctr_dec u_dec (
        .opc     (opc_reg),
        .funct3  (funct3_reg),
        .f7b5    (f7b5_reg),
        .alu_ctr (dec_ctr),
        .illegal (dec_illegal)
    );

    assign pc_plus4 = pc_reg + XLEN'(4);
    assign take_now = (opc_reg == OPC_BRANCH) ? branch_taken(funct3_reg, alu_zero, alu_less)
                                              : (opc_reg == OPC_JAL || opc_reg == OPC_JALR);

    // ALU drive kept apart from next-state logic so the flags feedback never forms a block-level loop.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = '0;
        if (state_reg == ST_EX1 && !dec_illegal) begin
            alu_ctr = dec_ctr;
            case (opc_reg)
                OPC_OP, OPC_BRANCH: begin alu_a = rs1_reg; alu_b = rs2_reg; end
                OPC_OPIMM:          begin alu_a = rs1_reg; alu_b = imm_reg; end
                OPC_LUI:            alu_b = imm_reg;
                OPC_AUIPC:          begin alu_a = pc_reg;  alu_b = imm_reg; end
                default:            begin alu_a = pc_reg;  alu_b = XLEN'(4); end
            endcase
        end else if (state_reg == ST_EX2) begin
            alu_a   = (opc_reg == OPC_JALR) ? rs1_reg : pc_reg;
            alu_b   = imm_reg;
            alu_ctr = ALU_ADD;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_EX1;
            ST_EX1:  state_next = (!dec_illegal && take_now) ? ST_EX2 : ST_RESP;
            ST_EX2:  state_next = ST_RESP;
            ST_RESP: if (out_valid_reg && out_ready) state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            imm_reg       <= '0;
            opc_reg       <= '0;
            funct3_reg    <= '0;
            f7b5_reg      <= 1'b0;
            rd_val_reg    <= '0;
            next_pc_reg   <= '0;
            wen_reg       <= 1'b0;
            taken_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    pc_reg     <= in_pc;
                    rs1_reg    <= in_rs1;
                    rs2_reg    <= in_rs2;
                    imm_reg    <= in_imm;
                    opc_reg    <= in_opc;
                    funct3_reg <= in_funct3;
                    f7b5_reg   <= in_f7b5;
                end
                ST_EX1: begin
                    illegal_reg <= dec_illegal;
                    wen_reg     <= !dec_illegal && opc_reg != OPC_BRANCH;
                    rd_val_reg  <= (dec_illegal || opc_reg == OPC_BRANCH) ? '0 : alu_out;
                    taken_reg   <= !dec_illegal && take_now;
                    next_pc_reg <= pc_plus4;
                end
                ST_EX2: begin
                    next_pc_reg <= (opc_reg == OPC_JALR) ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
                end
                ST_RESP: begin
                    // Results are presented one cycle after entering RESP.
                    if (!out_valid_reg)
                        out_valid_reg <= 1'b1;
                    else if (out_ready)
                        out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign out_valid   = out_valid_reg;
    assign out_rd_val  = rd_val_reg;
    assign out_wen     = wen_reg;
    assign out_next_pc = next_pc_reg;
    assign out_taken   = taken_reg;
    assign out_illegal = illegal_reg;

`ifdef EXU_PERF_CNT_EN
    logic [1:0] perf_inc;
    assign perf_inc = {out_valid_reg && out_ready && taken_reg, out_valid_reg && out_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (perf_inc[gi])
                    cnt_reg <= cnt_reg + 32'd1;
            end
        end
    endgenerate

    assign perf_retired = g_perf[0].cnt_reg;
    assign perf_taken   = g_perf[1].cnt_reg;
`else
    assign perf_retired = '0;
    assign perf_taken   = '0;
`endif

endmodule

// File: tb/tb_exu_seq.sv
// Scoreboard bench for exu_seq: directed instructions, behavioural ALU, decoupled response monitor.
module tb_exu_seq;
    import exu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [2:0]  in_opc, in_funct3;
    logic        in_f7b5;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctr;
    logic        alu_zero, alu_less;
    logic        out_valid, out_ready;
    logic [31:0] out_rd_val, out_next_pc;
    logic        out_wen, out_taken, out_illegal;
    logic [31:0] perf_retired, perf_taken;

    exu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_opc(in_opc), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_less(alu_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_val(out_rd_val), .out_wen(out_wen), .out_next_pc(out_next_pc),
        .out_taken(out_taken), .out_illegal(out_illegal),
        .perf_retired(perf_retired), .perf_taken(perf_taken)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        case (alu_ctr)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1000: alu_out = alu_a - alu_b;
            4'b0001: alu_out = alu_a << alu_b[4:0];
            4'b0010: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1010: alu_out = {31'd0, alu_a < alu_b};
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b1101: alu_out = $signed(alu_a) >>> alu_b[4:0];
            4'b0110: alu_out = alu_a | alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_b;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_a == alu_b);
        alu_less = (alu_ctr == 4'b1010) ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
    end

    typedef struct {
        logic [31:0] rd;
        logic [31:0] npc;
        logic        wen;
        logic        taken;
        logic        ill;
        int          lat;
        longint      acc_t;
    } exp_t;

    exp_t   q[$];
    exp_t   cur;
    bit     have_cur = 1'b0;
    int     checks = 0;
    int     fails = 0;
    int     n_resp = 0;
    int     exp_retired = 0;
    int     exp_taken = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected record when a response first appears, then re-check it every cycle it is held.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!have_cur) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp: got rd=%h npc=%h with no expected entry", out_rd_val, out_next_pc);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    n_resp++;
                    chk("latency", 32'(($time - cur.acc_t - 5) / 10), 32'(cur.lat));
                    $display("resp %0d: rd=%h wen=%0b npc=%h taken=%0b illegal=%0b",
                             n_resp, out_rd_val, out_wen, out_next_pc, out_taken, out_illegal);
                end
            end
            if (have_cur) begin
                chk("rd_val",  out_rd_val,  cur.rd);
                chk("wen",     32'(out_wen),     32'(cur.wen));
                chk("next_pc", out_next_pc, cur.npc);
                chk("taken",   32'(out_taken),   32'(cur.taken));
                chk("illegal", 32'(out_illegal), 32'(cur.ill));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && have_cur) begin
            have_cur = 1'b0;
            exp_retired++;
            if (cur.taken) exp_taken++;
        end
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [2:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [31:0] rd, input logic wen,
                         input logic [31:0] npc, input logic taken, input logic ill,
                         input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_opc = opc; in_funct3 = f3; in_f7b5 = f7; in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        e.rd = rd; e.npc = npc; e.wen = wen; e.taken = taken; e.ill = ill; e.lat = lat;
        e.acc_t = $time + 5;
        if (push) q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) @(negedge clk);
        chk("drain_queue", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_opc = '0; in_funct3 = '0; in_f7b5 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wen",       32'(out_wen),   32'd0);
        chk("rst_taken",     32'(out_taken), 32'd0);
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        chk("rst_rd_val",    out_rd_val,  32'd0);
        chk("rst_next_pc",   out_next_pc, 32'd0);
        chk("rst_alu_a",     alu_a, 32'd0);
        chk("rst_alu_b",     alu_b, 32'd0);
        chk("rst_alu_ctr",   32'(alu_ctr), 32'd0);
        chk("rst_perf_ret",  perf_retired, 32'd0);
        chk("rst_perf_tkn",  perf_taken, 32'd0);
        rst_n = 1'b1;

        //     pc            rs1           rs2         imm           opc         f3     f7    rd            wen   npc           tkn   ill  lat
        issue(32'h40,       32'd5,        32'd7,      32'd0,        OPC_OP,     3'b000, 1'b0, 32'd12,       1'b1, 32'h44,       1'b0, 1'b0, 2, 1);
        issue(32'h44,       32'h80000000, 32'd4,      32'd0,        OPC_OP,     3'b101, 1'b1, 32'hF8000000, 1'b1, 32'h48,       1'b0, 1'b0, 2, 1);
        issue(32'h48,       32'd5,        32'd7,      32'd0,        OPC_OP,     3'b000, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h4C,       1'b0, 1'b0, 2, 1);
        issue(32'h4C,       32'h0000F0F0, 32'd0,      32'h00000FF0, OPC_OPIMM,  3'b100, 1'b0, 32'h0000FF00, 1'b1, 32'h50,       1'b0, 1'b0, 2, 1);
        issue(32'h100,      32'hFFFFFFFF, 32'd1,      32'h20,       OPC_BRANCH, 3'b100, 1'b0, 32'd0,        1'b0, 32'h120,      1'b1, 1'b0, 3, 1);
        issue(32'h100,      32'hFFFFFFFF, 32'd1,      32'h20,       OPC_BRANCH, 3'b111, 1'b0, 32'd0,        1'b0, 32'h120,      1'b1, 1'b0, 3, 1);
        issue(32'h200,      32'd3,        32'd4,      32'h40,       OPC_BRANCH, 3'b000, 1'b0, 32'd0,        1'b0, 32'h204,      1'b0, 1'b0, 2, 1);
        issue(32'h80000000, 32'h1001,     32'd0,      32'd2,        OPC_JALR,   3'b000, 1'b0, 32'h80000004, 1'b1, 32'h1002,     1'b1, 1'b0, 3, 1);
        issue(32'h300,      32'd0,        32'd0,      32'h12345000, OPC_LUI,    3'b000, 1'b0, 32'h12345000, 1'b1, 32'h304,      1'b0, 1'b0, 2, 1);
        issue(32'h300,      32'd0,        32'd0,      32'h1000,     OPC_AUIPC,  3'b000, 1'b0, 32'h1300,     1'b1, 32'h304,      1'b0, 1'b0, 2, 1);
        issue(32'h400,      32'd1,        32'd2,      32'd0,        3'd7,       3'b000, 1'b0, 32'd0,        1'b0, 32'h404,      1'b0, 1'b1, 2, 1);
        issue(32'h500,      32'd1,        32'd2,      32'h10,       OPC_BRANCH, 3'b010, 1'b0, 32'd0,        1'b0, 32'h504,      1'b0, 1'b1, 2, 1);
        issue(32'h600,      32'd1,        32'd2,      32'd0,        OPC_OP,     3'b100, 1'b1, 32'd0,        1'b0, 32'h604,      1'b0, 1'b1, 2, 1);
        issue(32'hFFFFFFFC, 32'd0,        32'd0,      32'd8,        OPC_JAL,    3'b000, 1'b0, 32'd0,        1'b1, 32'd4,        1'b1, 1'b0, 3, 1);
        drain();

        // Back-pressure: response must hold while out_ready is low, with no new accept.
        @(negedge clk);
        out_ready = 1'b0;
        issue(32'h700, 32'd9, 32'd3, 32'd0, OPC_OP, 3'b110, 1'b0, 32'd11, 1'b1, 32'h704, 1'b0, 1'b0, 2, 1);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        drain();

        // Reset while the second pass of a JAL is in flight.
        issue(32'h800, 32'd0, 32'd0, 32'h10, OPC_JAL, 3'b000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3, 0);
        @(negedge clk);
        chk("ex2_alu_b", alu_b, 32'h10);
        chk("ex2_alu_a", alu_a, 32'h800);
        rst_n = 1'b0;
        exp_retired = 0;
        exp_taken = 0;
        @(negedge clk);
        chk("rst_ex2_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ex2_in_ready",  32'(in_ready),  32'd1);
        chk("rst_ex2_alu_b",     alu_b, 32'd0);
        chk("rst_ex2_rd_val",    out_rd_val, 32'd0);
        chk("rst_ex2_next_pc",   out_next_pc, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_ex2_no_resp", 32'(out_valid), 32'd0);

        // Three ops, one taken, for the counters.
        issue(32'h900, 32'd20, 32'd22, 32'd0, OPC_OP,     3'b000, 1'b0, 32'd42, 1'b1, 32'h904, 1'b0, 1'b0, 2, 1);
        issue(32'h904, 32'd0,  32'd0,  32'h100, OPC_JAL,  3'b000, 1'b0, 32'h908, 1'b1, 32'hA04, 1'b1, 1'b0, 3, 1);
        issue(32'hA04, 32'd5,  32'd5,  32'h40, OPC_BRANCH, 3'b001, 1'b0, 32'd0, 1'b0, 32'hA08, 1'b0, 1'b0, 2, 1);
        drain();
        @(negedge clk);
`ifdef EXU_PERF_CNT_EN
        chk("perf_retired", perf_retired, 32'(exp_retired));
        chk("perf_taken",   perf_taken,   32'(exp_taken));
`else
        chk("perf_retired_off", perf_retired, 32'd0);
        chk("perf_taken_off",   perf_taken,   32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
